// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the memory responder.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam logic [63:0] BASE_DEFAULT   = 64'h8000_0000;
  localparam int unsigned WORD_OFS       = 3;
  localparam int unsigned DATA_W_DEFAULT = 64;
  localparam int unsigned STRB_W_DEFAULT = DATA_W_DEFAULT / 8;

  // Byte-strobe width for a given data width.
  function automatic int unsigned strb_width(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response channel between the core-side requester and the responder.
interface mem_responder_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
) ();
  import mem_resp_pkg::*;

  localparam int unsigned STRB_W = strb_width(DATA_W);

  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              req_wen;
  logic [DATA_W-1:0] req_wdata;
  logic [STRB_W-1:0] req_wstrb;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_wstrb, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_wstrb, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/mem_array.sv
// Word-organised storage with byte-enabled writes and a registered read port.
module mem_array #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int unsigned STRB_W = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_we,
  input  logic              i_clr,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [STRB_W-1:0] i_wstrb,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Byte-lane write on an enabled write commit; contents survive reset.
  always_ff @(posedge clk) begin
    if (i_en && i_we) begin
      for (int i = 0; i < int'(STRB_W); i++) begin
        if (i_wstrb[i]) r_mem[i_idx][i*8 +: 8] <= i_wdata[i*8 +: 8];
      end
    end
  end

  // Read data is captured on a read commit and zeroed otherwise when cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_en && !i_we) begin
      r_rdata <= r_mem[i_idx];
    end else if (i_en || i_clr) begin
      r_rdata <= '0;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with fixed access latency.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned       ADDR_W  = 64,
  parameter int unsigned       DATA_W  = 64,
  parameter int unsigned       DEPTH   = 1024,
  parameter logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_DEFAULT),
  parameter int unsigned       LATENCY = 2
) (
  input logic            clk,
  input logic            rst,
  mem_responder_if.slave bus
);

  localparam int unsigned STRB_W   = strb_width(DATA_W);
  localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam bit          ZERO_LAT = (LATENCY == 0);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY == 0) ? 0 : LATENCY - 1);

  state_e            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_wen;
  logic [DATA_W-1:0] r_wdata;
  logic [STRB_W-1:0] r_wstrb;
  logic              r_req_ready;
  logic              r_resp_valid;
  logic              r_resp_err;

  logic [ADDR_W-1:0] w_c_addr;
  logic              w_c_wen;
  logic [DATA_W-1:0] w_c_wdata;
  logic [STRB_W-1:0] w_c_wstrb;
  logic [ADDR_W-1:0] w_off;
  logic [ADDR_W-1:0] w_idx_full;
  logic              w_in_range;
  logic              w_accept;
  logic              w_commit;
  logic              w_arr_en;
  logic              w_clr;
  logic [DATA_W-1:0] w_arr_rdata;

  // With zero latency the commit happens on the accept edge, so use the live request.
  assign w_c_addr  = ZERO_LAT ? bus.req_addr  : r_addr;
  assign w_c_wen   = ZERO_LAT ? bus.req_wen   : r_wen;
  assign w_c_wdata = ZERO_LAT ? bus.req_wdata : r_wdata;
  assign w_c_wstrb = ZERO_LAT ? bus.req_wstrb : r_wstrb;

  // Range check at full address width; low address bits select a lane and are ignored.
  assign w_off      = w_c_addr - BASE;
  assign w_idx_full = w_off >> WORD_OFS;
  assign w_in_range = (w_c_addr >= BASE) && (w_idx_full < ADDR_W'(DEPTH));

  assign w_accept = (r_state == IDLE) && bus.req_valid;
  assign w_commit = ZERO_LAT ? w_accept : ((r_state == WAIT) && (r_cnt == '0));
  assign w_arr_en = w_commit && w_in_range;
  assign w_clr    = (r_state == RESP) && bus.resp_ready;

  mem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W),
    .STRB_W (STRB_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_arr_en),
    .i_we    (w_c_wen),
    .i_clr   (w_clr),
    .i_idx   (w_idx_full[IDX_W-1:0]),
    .i_wdata (w_c_wdata),
    .i_wstrb (w_c_wstrb),
    .o_rdata (w_arr_rdata)
  );

  // Request/response sequencing: accept, wait out the latency, hold the response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_wen        <= 1'b0;
      r_wdata      <= '0;
      r_wstrb      <= '0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_addr      <= bus.req_addr;
            r_wen       <= bus.req_wen;
            r_wdata     <= bus.req_wdata;
            r_wstrb     <= bus.req_wstrb;
            r_req_ready <= 1'b0;
            if (ZERO_LAT) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
              r_resp_err   <= !w_in_range;
            end else begin
              r_state <= WAIT;
              r_cnt   <= CNT_LOAD;
            end
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
            r_resp_err   <= !w_in_range;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_req_ready  <= 1'b1;
          end
        end
        default: begin
          r_state      <= IDLE;
          r_req_ready  <= 1'b1;
          r_resp_valid <= 1'b0;
          r_resp_err   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready  = r_req_ready;
  assign bus.resp_valid = r_resp_valid;
  assign bus.resp_err   = r_resp_err;
  assign bus.resp_rdata = w_arr_rdata;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder at LATENCY=2 and LATENCY=0.
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sel = 1'b0;  // 0 drives the LATENCY=2 instance, 1 the LATENCY=0 instance

  logic        req_valid = 1'b0;
  logic [63:0] req_addr  = '0;
  logic        req_wen   = 1'b0;
  logic [63:0] req_wdata = '0;
  logic [7:0]  req_wstrb = '0;
  logic        resp_ready = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder_if #(.ADDR_W(64), .DATA_W(64)) if2 ();
  mem_responder_if #(.ADDR_W(64), .DATA_W(64)) if0 ();

  assign if2.req_valid  = req_valid & ~sel;
  assign if2.req_addr   = req_addr;
  assign if2.req_wen    = req_wen;
  assign if2.req_wdata  = req_wdata;
  assign if2.req_wstrb  = req_wstrb;
  assign if2.resp_ready = resp_ready;
  assign if0.req_valid  = req_valid & sel;
  assign if0.req_addr   = req_addr;
  assign if0.req_wen    = req_wen;
  assign if0.req_wdata  = req_wdata;
  assign if0.req_wstrb  = req_wstrb;
  assign if0.resp_ready = resp_ready;

  mem_responder #(.LATENCY(2)) u_dut2 (.clk(clk), .rst(rst), .bus(if2));
  mem_responder #(.LATENCY(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));

  logic        m_req_ready, m_resp_valid, m_resp_err;
  logic [63:0] m_resp_rdata;
  assign m_req_ready  = sel ? if0.req_ready  : if2.req_ready;
  assign m_resp_valid = sel ? if0.resp_valid : if2.resp_valid;
  assign m_resp_err   = sel ? if0.resp_err   : if2.resp_err;
  assign m_resp_rdata = sel ? if0.resp_rdata : if2.resp_rdata;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full transaction with resp_ready=1; lat counts edges from drive to response visible.
  task automatic txn(input string tag, input logic wen, input logic [63:0] addr,
                     input logic [63:0] wdata, input logic [7:0] wstrb,
                     output logic [63:0] rdata, output logic err, output int lat, output int acc);
    logic got;
    got = 1'b0; lat = 0; acc = 0;
    @(negedge clk);
    req_addr = addr; req_wen = wen; req_wdata = wdata; req_wstrb = wstrb;
    resp_ready = 1'b1; req_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      lat++;
      if (i == 0) begin
        req_valid = 1'b0;
        acc = cyc;
      end
      if (m_resp_valid) begin
        got = 1'b1;
        break;
      end
    end
    check({tag, ".resp_seen"}, 64'(got), 64'd1);
    rdata = m_resp_rdata;
    err   = m_resp_err;
    @(posedge clk); #1;
    check({tag, ".after_hs"}, 64'({m_resp_valid, m_req_ready, m_resp_rdata == 64'd0}), 64'b011);
  endtask

  task automatic rd_chk(input string tag, input logic [63:0] addr, input logic [63:0] exp_d,
                        input logic exp_e, output int acc);
    logic [63:0] d; logic e; int lat;
    txn(tag, 1'b0, addr, 64'd0, 8'd0, d, e, lat, acc);
    check({tag, ".rdata"}, d, exp_d);
    check({tag, ".err"}, 64'(e), 64'(exp_e));
    check({tag, ".lat"}, 64'(lat), sel ? 64'd1 : 64'd3);
  endtask

  task automatic wr_chk(input string tag, input logic [63:0] addr, input logic [63:0] data,
                        input logic [7:0] strb, input logic exp_e, output int acc);
    logic [63:0] d; logic e; int lat;
    txn(tag, 1'b1, addr, data, strb, d, e, lat, acc);
    check({tag, ".rdata"}, d, 64'd0);
    check({tag, ".err"}, 64'(e), 64'(exp_e));
    check({tag, ".lat"}, 64'(lat), sel ? 64'd1 : 64'd3);
  endtask

  initial begin
    int a0, a1, a2;
    logic seen;

    // Reset values while held in reset
    repeat (2) @(posedge clk);
    #1;
    check("rst.req_ready", 64'(m_req_ready), 64'd1);
    check("rst.resp_valid", 64'(m_resp_valid), 64'd0);
    check("rst.resp_err", 64'(m_resp_err), 64'd0);
    check("rst.resp_rdata", m_resp_rdata, 64'd0);
    @(negedge clk) rst = 1'b0;

    // Reset asserted mid-WAIT aborts the request
    @(negedge clk);
    req_addr = 64'h8000_0000; req_wen = 1'b0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("abort.accepted", 64'(m_req_ready), 64'd0);
    #2 rst = 1'b1;
    #1;
    check("abort.async_ready", 64'(m_req_ready), 64'd1);
    check("abort.async_valid", 64'(m_resp_valid), 64'd0);
    check("abort.async_rdata", m_resp_rdata, 64'd0);
    @(negedge clk) rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (m_resp_valid) seen = 1'b1;
    end
    check("abort.no_resp", 64'(seen), 64'd0);
    check("abort.ready", 64'(m_req_ready), 64'd1);

    // Full write then read with offset address; throughput LATENCY+2
    wr_chk("wr1", 64'h8000_0008, 64'h1122334455667788, 8'hFF, 1'b0, a0);
    rd_chk("rd1", 64'h8000_000C, 64'h1122334455667788, 1'b0, a1);
    check("l2.period", 64'(a1 - a0), 64'd4);

    // Partial strobe merge
    wr_chk("wr2", 64'h8000_0008, 64'hAAAAAAAA_BBBBBBBB, 8'h0F, 1'b0, a0);
    rd_chk("rd2", 64'h8000_0008, 64'h11223344_BBBBBBBB, 1'b0, a0);

    // Zero strobe is a no-op write with a normal response
    wr_chk("wr0", 64'h8000_0008, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 1'b0, a0);
    rd_chk("rd0", 64'h8000_0008, 64'h11223344_BBBBBBBB, 1'b0, a0);

    // Range boundaries
    wr_chk("wr_w0", 64'h8000_0000, 64'h0123456789ABCDEF, 8'hFF, 1'b0, a0);
    wr_chk("wr_last", 64'h8000_1FF8, 64'hCAFEF00D_12345678, 8'hFF, 1'b0, a0);
    rd_chk("rd_last", 64'h8000_1FFF, 64'hCAFEF00D_12345678, 1'b0, a0);
    rd_chk("err_lo", 64'h7FFF_FFF8, 64'd0, 1'b1, a0);
    rd_chk("err_hi", 64'h8000_2000, 64'd0, 1'b1, a0);
    rd_chk("err_zero", 64'h0, 64'd0, 1'b1, a0);
    wr_chk("err_wr", 64'h8000_2000, 64'hDEAD_DEAD_DEAD_DEAD, 8'hFF, 1'b1, a0);
    rd_chk("keep_w0", 64'h8000_0000, 64'h0123456789ABCDEF, 1'b0, a0);
    rd_chk("keep_last", 64'h8000_1FF8, 64'hCAFEF00D_12345678, 1'b0, a0);
    rd_chk("keep_w1", 64'h8000_0008, 64'h11223344_BBBBBBBB, 1'b0, a0);

    // Backpressure: response held while resp_ready=0; new request ignored
    @(negedge clk);
    req_addr = 64'h8000_0008; req_wen = 1'b0; resp_ready = 1'b0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (m_resp_valid) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    check("hold.resp_seen", 64'(seen), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (i == 1) begin
        req_wen = 1'b1; req_wdata = 64'd0; req_wstrb = 8'hFF; req_valid = 1'b1;
      end
      if (i == 2) req_valid = 1'b0;
      check("hold.valid", 64'(m_resp_valid), 64'd1);
      check("hold.rdata", m_resp_rdata, 64'h11223344_BBBBBBBB);
      check("hold.err", 64'(m_resp_err), 64'd0);
      check("hold.req_ready", 64'(m_req_ready), 64'd0);
    end
    @(negedge clk) begin resp_ready = 1'b1; req_wen = 1'b0; end
    @(posedge clk); #1;
    check("hold.release", 64'({m_resp_valid, m_req_ready, m_resp_err}), 64'b010);
    check("hold.rdata_clr", m_resp_rdata, 64'd0);
    rd_chk("hold.unchanged", 64'h8000_0008, 64'h11223344_BBBBBBBB, 1'b0, a0);

    // LATENCY=0 instance: response next cycle, one transaction every 2 cycles
    sel = 1'b1;
    wr_chk("z.wr1", 64'h8000_0010, 64'hDEADBEEF_00000001, 8'hFF, 1'b0, a0);
    wr_chk("z.wr2", 64'h8000_0018, 64'h00000002_FEEDFACE, 8'hFF, 1'b0, a1);
    check("z.wr_period", 64'(a1 - a0), 64'd2);
    rd_chk("z.rd1", 64'h8000_0010, 64'hDEADBEEF_00000001, 1'b0, a0);
    rd_chk("z.rd2", 64'h8000_001C, 64'h00000002_FEEDFACE, 1'b0, a1);
    rd_chk("z.err", 64'h8000_2000, 64'd0, 1'b1, a2);
    check("z.period1", 64'(a1 - a0), 64'd2);
    check("z.period2", 64'(a2 - a1), 64'd2);
    wr_chk("z.raw_wr", 64'h8000_0010, 64'h5555_0000_0000_0000, 8'hC0, 1'b0, a0);
    rd_chk("z.raw_rd", 64'h8000_0010, 64'h5555BEEF_00000001, 1'b0, a1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
